// File: rtl/iiq_issue_select_if.sv
// Queue-side and execute-side signals of the integer issue-queue select stage.
// The master modport is the select block; the slave modport is the queue/execute environment.
`ifndef IIQ_N_ENTRIES
`define IIQ_N_ENTRIES 4
`endif

interface iiq_issue_select_if #(
   parameter int N_ENTRIES     = `IIQ_N_ENTRIES,
   parameter int TAG_WIDTH     = 6,
   parameter int PAYLOAD_WIDTH = 32,
   parameter int N_CDB         = 2
);
   localparam int ENTRY_WIDTH = PAYLOAD_WIDTH + 3*TAG_WIDTH + 2;
   localparam int CNT_WIDTH   = $clog2(N_ENTRIES) + 1;

   logic [N_ENTRIES*ENTRY_WIDTH-1:0] entry_douts;
   logic [CNT_WIDTH-1:0]             entry_count;
   logic [N_CDB-1:0]                 cdb_valid;
   logic [N_CDB*TAG_WIDTH-1:0]       cdb_tag;
   logic                             flush;
   logic                             deq_ready;
   logic [N_ENTRIES-1:0]             deq_sel_onehot;
   logic [N_ENTRIES-1:0]             wr_en;
   logic [N_ENTRIES*ENTRY_WIDTH-1:0] wr_data;
   logic                             iss_valid;
   logic                             iss_ready;
   logic [PAYLOAD_WIDTH-1:0]         iss_payload;
   logic [TAG_WIDTH-1:0]             iss_dst_tag;

   // iss_valid/iss_ready: a transfer happens on every edge where both are high; while iss_valid
   // is high and iss_ready low the payload is held. deq_ready/deq_sel_onehot is a zero-cycle dequeue.
   modport master (
      input  entry_douts, entry_count, cdb_valid, cdb_tag, flush, iss_ready,
      output deq_ready, deq_sel_onehot, wr_en, wr_data, iss_valid, iss_payload, iss_dst_tag
   );
   modport slave (
      output entry_douts, entry_count, cdb_valid, cdb_tag, flush, iss_ready,
      input  deq_ready, deq_sel_onehot, wr_en, wr_data, iss_valid, iss_payload, iss_dst_tag
   );
endinterface

// File: rtl/iiq_issue_select.sv
// IIQ issue stage: operand wakeup, oldest-ready select and issue register with self-wakeup.
// Optional macro IIQ_WAKEUP_BYPASS_EN lets an entry woken this cycle be selected this cycle.
`ifndef IIQ_N_ENTRIES
`define IIQ_N_ENTRIES 4
`endif

module iiq_issue_select #(
   parameter int N_ENTRIES     = `IIQ_N_ENTRIES,
   parameter int TAG_WIDTH     = 6,
   parameter int PAYLOAD_WIDTH = 32,
   parameter int N_CDB         = 2,
   parameter int WAKEUP_DELAY  = 1,
   parameter int ENTRY_WIDTH   = PAYLOAD_WIDTH + 3*TAG_WIDTH + 2
) (
   input logic               clk,
   input logic               rst,
   iiq_issue_select_if.master bus
);
   localparam int CNT_WIDTH = $clog2(N_ENTRIES) + 1;
   localparam int S1_LSB    = 1;
   localparam int S2_RDY    = TAG_WIDTH + 1;
   localparam int S2_LSB    = TAG_WIDTH + 2;
   localparam int DST_LSB   = 2*TAG_WIDTH + 2;
   localparam int PAY_LSB   = 3*TAG_WIDTH + 2;

   logic [N_ENTRIES-1:0]             valid;
   logic [N_ENTRIES-1:0]             rdy;
   logic [N_ENTRIES-1:0]             sel;
   logic [N_ENTRIES-1:0]             wr_en_c;
   logic [N_ENTRIES*ENTRY_WIDTH-1:0] wr_data_c;
   logic [PAYLOAD_WIDTH-1:0]         sel_payload;
   logic [TAG_WIDTH-1:0]             sel_dst;
   logic                             can_accept;
   logic                             handoff;

   logic                             iss_valid_q;
   logic [PAYLOAD_WIDTH-1:0]         iss_payload_q;
   logic [TAG_WIDTH-1:0]             iss_dst_q;

   logic [WAKEUP_DELAY-1:0]          swk_v;
   logic [TAG_WIDTH-1:0]             swk_tag [WAKEUP_DELAY];

   assign can_accept = !iss_valid_q || bus.iss_ready || bus.flush;
   assign handoff    = iss_valid_q && bus.iss_ready && !bus.flush;

   always_comb begin
      logic [ENTRY_WIDTH-1:0] ent;
      logic [ENTRY_WIDTH-1:0] img;
      logic [TAG_WIDTH-1:0]   s1t;
      logic [TAG_WIDTH-1:0]   s2t;
      logic                   m1;
      logic                   m2;
      logic                   h1;
      logic                   h2;
      logic                   found;
      ent         = '0;
      img         = '0;
      s1t         = '0;
      s2t         = '0;
      m1          = 1'b0;
      m2          = 1'b0;
      h1          = 1'b0;
      h2          = 1'b0;
      found       = 1'b0;
      valid       = '0;
      rdy         = '0;
      sel         = '0;
      wr_en_c     = '0;
      wr_data_c   = '0;
      sel_payload = '0;
      sel_dst     = '0;
      for (int i = 0; i < N_ENTRIES; i++) begin
         ent      = bus.entry_douts[i*ENTRY_WIDTH +: ENTRY_WIDTH];
         s1t      = ent[S1_LSB +: TAG_WIDTH];
         s2t      = ent[S2_LSB +: TAG_WIDTH];
         valid[i] = CNT_WIDTH'(i) < bus.entry_count;
         // Broadcast set: valid CDB ports plus the self-wakeup output stage.
         m1 = swk_v[WAKEUP_DELAY-1] && (swk_tag[WAKEUP_DELAY-1] == s1t);
         m2 = swk_v[WAKEUP_DELAY-1] && (swk_tag[WAKEUP_DELAY-1] == s2t);
         for (int p = 0; p < N_CDB; p++) begin
            if (bus.cdb_valid[p] && (bus.cdb_tag[p*TAG_WIDTH +: TAG_WIDTH] == s1t)) m1 = 1'b1;
            if (bus.cdb_valid[p] && (bus.cdb_tag[p*TAG_WIDTH +: TAG_WIDTH] == s2t)) m2 = 1'b1;
         end
         h1 = valid[i] && !ent[0] && m1;
         h2 = valid[i] && !ent[S2_RDY] && m2;
         if ((h1 || h2) && !rst) begin
            img         = ent;
            img[0]      = ent[0] | h1;
            img[S2_RDY] = ent[S2_RDY] | h2;
            wr_en_c[i]  = 1'b1;
            wr_data_c[i*ENTRY_WIDTH +: ENTRY_WIDTH] = img;
         end
`ifdef IIQ_WAKEUP_BYPASS_EN
         rdy[i] = valid[i] && (ent[0] || h1) && (ent[S2_RDY] || h2);
`else
         rdy[i] = valid[i] && ent[0] && ent[S2_RDY];
`endif
      end
      for (int i = 0; i < N_ENTRIES; i++) begin
         if (rdy[i] && !found) begin
            sel[i] = 1'b1;
            found  = 1'b1;
         end
      end
      if (!can_accept || bus.flush || rst) sel = '0;
      for (int i = 0; i < N_ENTRIES; i++) begin
         ent         = bus.entry_douts[i*ENTRY_WIDTH +: ENTRY_WIDTH];
         sel_payload = sel_payload | (ent[PAY_LSB +: PAYLOAD_WIDTH] & {PAYLOAD_WIDTH{sel[i]}});
         sel_dst     = sel_dst | (ent[DST_LSB +: TAG_WIDTH] & {TAG_WIDTH{sel[i]}});
      end
   end

   // Flush beats handoff; a stalled micro-op is held until iss_ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         iss_valid_q   <= 1'b0;
         iss_payload_q <= '0;
         iss_dst_q     <= '0;
      end else if (bus.flush) begin
         iss_valid_q <= 1'b0;
      end else if (|sel) begin
         iss_valid_q   <= 1'b1;
         iss_payload_q <= sel_payload;
         iss_dst_q     <= sel_dst;
      end else if (bus.iss_ready) begin
         iss_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         swk_v <= '0;
      end else begin
         swk_v[0]   <= handoff;
         swk_tag[0] <= iss_dst_q;
         for (int k = 1; k < WAKEUP_DELAY; k++) begin
            swk_v[k]   <= swk_v[k-1];
            swk_tag[k] <= swk_tag[k-1];
         end
      end
   end

   assign bus.deq_sel_onehot = sel;
   assign bus.deq_ready      = |sel;
   assign bus.wr_en          = wr_en_c;
   assign bus.wr_data        = wr_data_c;
   assign bus.iss_valid      = iss_valid_q;
   assign bus.iss_payload    = iss_payload_q;
   assign bus.iss_dst_tag    = iss_dst_q;

`ifndef SYNTHESIS
   a_sel_onehot0: assert property (@(posedge clk) $onehot0(sel));
   a_wr_in_range: assert property (@(posedge clk) disable iff (rst) (wr_en_c & ~valid) == '0);
   a_handoff_valid: assert property (@(posedge clk) disable iff (rst) handoff |-> iss_valid_q);
`endif
endmodule

// File: tb/tb_iiq_issue_select.sv
// Directed bench for iiq_issue_select: reset, oldest select, CDB/self wakeup, stall and flush.
// The bench plays the queue by hand: entry images are rewritten between cycles.
module tb_iiq_issue_select;
   localparam int N  = 4;
   localparam int TW = 6;
   localparam int PW = 32;
   localparam int NC = 2;
   localparam int WD = 1;
   localparam int EW = PW + 3*TW + 2;
`ifdef IIQ_WAKEUP_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [EW-1:0] ent [N];
   logic [2:0]    cnt;
   int            n_checks = 0;
   int            n_errors = 0;

   iiq_issue_select_if #(.N_ENTRIES(N), .TAG_WIDTH(TW), .PAYLOAD_WIDTH(PW), .N_CDB(NC)) bus ();

   iiq_issue_select #(
      .N_ENTRIES(N), .TAG_WIDTH(TW), .PAYLOAD_WIDTH(PW), .N_CDB(NC), .WAKEUP_DELAY(WD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [EW-1:0] mk(input logic [PW-1:0] p, input logic [TW-1:0] d,
                                        input logic [TW-1:0] s2t, input logic s2r,
                                        input logic [TW-1:0] s1t, input logic s1r);
      return {p, d, s2t, s2r, s1t, s1r};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic put();
      for (int i = 0; i < N; i++) bus.entry_douts[i*EW +: EW] = ent[i];
      bus.entry_count = cnt;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      cnt = 0;
      bus.flush = 1'b0;
      bus.cdb_valid = '0;
      bus.iss_ready = 1'b1;
      put();
      step();
      step();
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < N; i++) ent[i] = '0;
      cnt = 0;
      bus.cdb_valid = '0;
      bus.cdb_tag = '0;
      bus.flush = 1'b0;
      bus.iss_ready = 1'b1;
      put();
      step();

      // Reset priority: ready entries and a CDB hit are all ignored while rst is high.
      ent[0] = mk(32'h0101, 6'd1, 6'd0, 1'b1, 6'd0, 1'b1);
      ent[1] = mk(32'h0202, 6'd2, 6'd0, 1'b1, 6'd0, 1'b1);
      ent[2] = mk(32'h0303, 6'd3, 6'd0, 1'b1, 6'd3, 1'b0);
      cnt = 3;
      bus.cdb_valid = 2'b01;
      bus.cdb_tag = {6'd0, 6'd3};
      put();
      #1;
      check("rst_sel", bus.deq_sel_onehot, 4'b0000);
      check("rst_deq_ready", bus.deq_ready, 1'b0);
      check("rst_wr_en", bus.wr_en, 4'b0000);
      step();
      check("rst_iss_valid", bus.iss_valid, 1'b0);
      check("rst_iss_payload", bus.iss_payload, 32'h0);
      check("rst_iss_dst", bus.iss_dst_tag, 6'd0);
      rst = 1'b0;
      drain();

      // Oldest ready entry wins.
      ent[0] = mk(32'h1000, 6'd16, 6'd0, 1'b1, 6'd7, 1'b0);
      ent[1] = mk(32'h1111, 6'd17, 6'd0, 1'b1, 6'd0, 1'b1);
      ent[2] = mk(32'h2222, 6'd18, 6'd0, 1'b1, 6'd0, 1'b1);
      cnt = 3;
      put();
      #1;
      check("old_sel", bus.deq_sel_onehot, 4'b0010);
      check("old_deq_ready", bus.deq_ready, 1'b1);
      check("old_wr_en", bus.wr_en, 4'b0000);
      step();
      check("old_iss_valid", bus.iss_valid, 1'b1);
      check("old_iss_payload", bus.iss_payload, 32'h1111);
      check("old_iss_dst", bus.iss_dst_tag, 6'd17);
      cnt = 0;
      put();
      step();
      check("old_handoff_clears", bus.iss_valid, 1'b0);
      drain();

      // CDB wakeup of src1 on port 0.
      ent[0] = mk(32'h3333, 6'd20, 6'd0, 1'b1, 6'd5, 1'b0);
      cnt = 1;
      bus.cdb_valid = 2'b01;
      bus.cdb_tag = {6'd0, 6'd5};
      put();
      #1;
      check("cdb_wr_en", bus.wr_en, 4'b0001);
      check("cdb_wr_data0", bus.wr_data[0 +: EW], mk(32'h3333, 6'd20, 6'd0, 1'b1, 6'd5, 1'b1));
      check("cdb_wr_data1", bus.wr_data[EW +: EW], 64'h0);
      check("cdb_sel_same", bus.deq_sel_onehot, {3'b000, BYP});
`ifdef IIQ_WAKEUP_BYPASS_EN
      step();
      cnt = 0;
      bus.cdb_valid = '0;
      put();
`else
      step();
      ent[0] = mk(32'h3333, 6'd20, 6'd0, 1'b1, 6'd5, 1'b1);
      bus.cdb_valid = '0;
      put();
      #1;
      check("cdb_sel_next", bus.deq_sel_onehot, 4'b0001);
      step();
      cnt = 0;
      put();
`endif
      check("cdb_iss_valid", bus.iss_valid, 1'b1);
      check("cdb_iss_payload", bus.iss_payload, 32'h3333);
      drain();

      // Both ports valid, stored-ready bits, and an entry beyond entry_count.
      ent[0] = mk(32'h7070, 6'd1, 6'd41, 1'b0, 6'd40, 1'b0);
      ent[1] = mk(32'h7171, 6'd2, 6'd41, 1'b1, 6'd40, 1'b1);
      ent[2] = mk(32'h7272, 6'd3, 6'd0, 1'b1, 6'd40, 1'b0);
      cnt = 2;
      bus.cdb_valid = 2'b11;
      bus.cdb_tag = {6'd41, 6'd40};
      put();
      #1;
      check("dual_wr_en", bus.wr_en, 4'b0001);
      check("dual_wr_data0", bus.wr_data[0 +: EW], mk(32'h7070, 6'd1, 6'd41, 1'b1, 6'd40, 1'b1));
      check("dual_wr_data2", bus.wr_data[2*EW +: EW], 64'h0);
      check("dual_sel", bus.deq_sel_onehot, BYP ? 4'b0001 : 4'b0010);
      drain();

      // Stall: hold for three cycles, then handoff and new load on the same edge.
      bus.iss_ready = 1'b0;
      ent[0] = mk(32'h4444, 6'd30, 6'd0, 1'b1, 6'd0, 1'b1);
      cnt = 1;
      put();
      #1;
      check("stall_first_sel", bus.deq_sel_onehot, 4'b0001);
      step();
      ent[0] = mk(32'h5555, 6'd31, 6'd0, 1'b1, 6'd0, 1'b1);
      put();
      for (int c = 0; c < 3; c++) begin
         #1;
         check("stall_deq_ready", bus.deq_ready, 1'b0);
         check("stall_iss_valid", bus.iss_valid, 1'b1);
         check("stall_iss_payload", bus.iss_payload, 32'h4444);
         step();
      end
      bus.iss_ready = 1'b1;
      #1;
      check("stall_release_sel", bus.deq_sel_onehot, 4'b0001);
      step();
      check("stall_new_payload", bus.iss_payload, 32'h5555);
      check("stall_new_valid", bus.iss_valid, 1'b1);
      ent[0] = mk(32'hAAAA, 6'd33, 6'd0, 1'b1, 6'd30, 1'b0);
      put();
      #1;
      check("stall_selfwake_wr_en", bus.wr_en, 4'b0001);
      drain();

      // Self-wakeup: producer tag 9 hands off in cycle t.
      ent[0] = mk(32'h9999, 6'd9, 6'd0, 1'b1, 6'd0, 1'b1);
      cnt = 1;
      put();
      step();
      check("self_prod_payload", bus.iss_payload, 32'h9999);
      ent[0] = mk(32'hC0C0, 6'd10, 6'd0, 1'b1, 6'd9, 1'b0);
      put();
      #1;
      check("self_t_wr_en", bus.wr_en, 4'b0000);
      check("self_t_sel", bus.deq_sel_onehot, 4'b0000);
      step();
      check("self_t1_wr_en", bus.wr_en, 4'b0001);
      check("self_t1_wr_data0", bus.wr_data[0 +: EW], mk(32'hC0C0, 6'd10, 6'd0, 1'b1, 6'd9, 1'b1));
      check("self_t1_sel", bus.deq_sel_onehot, {3'b000, BYP});
`ifdef IIQ_WAKEUP_BYPASS_EN
      step();
      cnt = 0;
      put();
`else
      step();
      ent[0] = mk(32'hC0C0, 6'd10, 6'd0, 1'b1, 6'd9, 1'b1);
      put();
      #1;
      check("self_t2_sel", bus.deq_sel_onehot, 4'b0001);
      step();
      cnt = 0;
      put();
`endif
      check("self_cons_valid", bus.iss_valid, 1'b1);
      check("self_cons_payload", bus.iss_payload, 32'hC0C0);
      drain();

      // Flush with a stalled micro-op and a valid self-wakeup stage.
      ent[0] = mk(32'h00A1, 6'd12, 6'd0, 1'b1, 6'd0, 1'b1);
      ent[1] = mk(32'h00B1, 6'd13, 6'd0, 1'b1, 6'd0, 1'b1);
      cnt = 2;
      put();
      step();
      ent[0] = ent[1];
      cnt = 1;
      put();
      step();
      check("flush_pre_payload", bus.iss_payload, 32'h00B1);
      bus.flush = 1'b1;
      bus.iss_ready = 1'b0;
      ent[0] = mk(32'h00C1, 6'd14, 6'd0, 1'b1, 6'd12, 1'b0);
      ent[1] = mk(32'h00D1, 6'd15, 6'd0, 1'b1, 6'd0, 1'b1);
      cnt = 2;
      put();
      #1;
      check("flush_sel", bus.deq_sel_onehot, 4'b0000);
      check("flush_deq_ready", bus.deq_ready, 1'b0);
      step();
      bus.flush = 1'b0;
      check("flush_iss_valid", bus.iss_valid, 1'b0);
      #1;
      check("flush_wr_en", bus.wr_en, 4'b0000);
      check("flush_after_sel", bus.deq_sel_onehot, 4'b0010);
      step();
      check("flush_reload", bus.iss_payload, 32'h00D1);

      // Flush outranks a simultaneous handoff: tag 15 must never broadcast.
      bus.flush = 1'b1;
      bus.iss_ready = 1'b1;
      ent[0] = mk(32'h00E1, 6'd16, 6'd15, 1'b0, 6'd0, 1'b1);
      cnt = 1;
      put();
      step();
      bus.flush = 1'b0;
      check("flushprio_iss_valid", bus.iss_valid, 1'b0);
      #1;
      check("flushprio_wr_en", bus.wr_en, 4'b0000);
      check("flushprio_sel", bus.deq_sel_onehot, 4'b0000);
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
